mips_multicycle_control: RTL and testbench
==========================================

# mips_multicycle_control

Multicycle control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback steps, and drives every datapath enable and select. It sits directly upstream of the single-cycle load-word datapath and replaces its hard-wired `regwrite=1` / `alucontrol=010` with per-state control. The datapath becomes a shared-memory multicycle machine.

## Interface
Parameters:
- `W`, default 32: width of the `instret` counter.

Ports:
- `clk`  in  1: clock; all state changes on its rising edge.
- `reset`  in  1: synchronous, active-high.
- `op`  in  6: `instr[31:26]`, taken from the datapath instruction register.
- `funct`  in  6: `instr[5:0]`.
- `zero`  in  1: ALU zero flag.
- `pcen`  out  1: PC write enable, equal to `pcwrite | (branch & zero)`.
- `pcwrite`, `branch`, `irwrite`, `regwrite`, `memwrite`  out  1 each: write enables.
- `iord`, `regdst`, `memtoreg`, `alusrca`  out  1 each: mux selects.
- `alusrcb`  out  2: 00 = regB, 01 = constant 4, 10 = signimm, 11 = signimm<<2.
- `pcsrc`  out  2: 00 = aluresult, 01 = aluout (register), 10 = jump target.
- `alucontrol`  out  3: same encoding as the ALU `F` input.
- `state`  out  4: current state, for debug.
- `instret`  out  W: count of retired instructions.

## Operation
- Moore FSM; the outputs are a combinational decode of `state` only. Any output not listed for a state is 0.
- States and their outputs:
  - FETCH(0): `irwrite`, `pcwrite`, `alusrcb=01`, aluop 00. Next state is DECODE.
  - DECODE(1): `alusrcb=11`, aluop 00. Next state by `op`:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 (R-type) → EXECUTE.
    - 000100 (beq) → BRANCH.
    - 001000 (addi) → ADDIEXEC.
    - 000010 (j) → JUMP.
    - Any other opcode → FETCH. The instruction is dropped and does not count toward `instret`.
  - MEMADR(2): `alusrca`, `alusrcb=10`, aluop 00. Next state is MEMREAD if lw, MEMWRITE if sw.
  - MEMREAD(3): `iord`. Next state is MEMWB.
  - MEMWB(4): `memtoreg`, `regwrite` (`regdst=0`). Next state is FETCH.
  - MEMWRITE(5): `iord`, `memwrite`. Next state is FETCH.
  - EXECUTE(6): `alusrca`, `alusrcb=00`, aluop 10. Next state is ALUWB.
  - ALUWB(7): `regdst`, `regwrite`. Next state is FETCH.
  - BRANCH(8): `alusrca`, aluop 01, `pcsrc=01`, `branch`. Next state is FETCH.
  - ADDIEXEC(9): `alusrca`, `alusrcb=10`, aluop 00. Next state is ADDIWB.
  - ADDIWB(10): `regwrite` (`regdst=0`, `memtoreg=0`). Next state is FETCH.
  - JUMP(11): `pcsrc=10`, `pcwrite`. Next state is FETCH.
  - Encodings 12–15 are illegal and go to FETCH on the next edge, with all enables 0.
- ALU decode from the internal 2-bit aluop:
  - 00 → 010 (add); 01 → 110 (sub).
  - 10 → by `funct`: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, any other funct→010.
  - 11 → 010.
- `instret` increments by 1 on each transition from a final state (MEMWB, MEMWRITE, ALUWB, BRANCH, ADDIWB, JUMP) into FETCH. It wraps from 2^W−1 to 0.

## Timing
- Reset behaviour:
  - `reset` high at an edge sets `state=FETCH` and `instret=0` after that edge.
  - While `reset` is high, `pcwrite`, `irwrite`, `regwrite`, `memwrite`, `branch` and `pcen` are forced to 0, regardless of state.
  - Reset mid-instruction abandons that instruction; it is not counted.
- Latency in cycles, FETCH included: lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; unknown opcode 2.
- `op`, `funct` and `zero` are sampled combinationally. `op` is used only in DECODE and MEMADR; `zero` only in BRANCH. These inputs must be stable before the edge.
- There are no stalls and no handshake; the FSM advances every cycle.

## Structure
- Shared package holds:
  - the state encodings (4-bit);
  - opcode constants `OP_LW`, `OP_SW`, `OP_RTYPE`, `OP_BEQ`, `OP_ADDI`, `OP_J`;
  - funct constants;
  - aluop codes;
  - `alusrcb` and `pcsrc` encodings.
- Sub-module `alu_decoder`: purely combinational, inputs (aluop, funct) → `alucontrol`. It is reused by the datapath test benches.
- The top level contains the state register, the next-state logic, the output decode, the `pcen` gate and the `instret` counter.

## Test plan
- Reset and lw:
  - Stimulus: hold `reset` for 2 cycles, then `op=100011`.
  - Required: `state` follows 0,1,2,3,4,0. `irwrite=pcwrite=1` only in cycle 0. `regwrite=memtoreg=1` only in state 4. `instret` goes 0→1.
- sw:
  - Stimulus: `op=101011`.
  - Required: states 0,1,2,5,0. `memwrite=iord=1` only in state 5. `regwrite` is never 1.
- R-type decode:
  - Stimulus: `op=0`, `funct` each of 100000, 100010, 100100, 100101, 101010, 111111.
  - Required: in EXECUTE, `alucontrol` = 010, 110, 000, 001, 111, 010 respectively. In ALUWB, `regdst=1`.
- beq:
  - Stimulus: `op=000100`, once with `zero=1` and once with `zero=0`.
  - Required: in BRANCH, `alucontrol=110` and `pcsrc=01`. `pcen` is 1 when `zero=1` and 0 when `zero=0`.
- j, addi and unknown opcode:
  - Stimulus: `op=000010`, then `op=001000`, then `op=111111`.
  - Required: j gives states 0,1,11,0 with `pcsrc=10` and `pcen=1`. addi gives 0,1,9,10,0. The unknown opcode gives 0,1,0. `instret` rises by exactly 2.
- Reset mid-instruction and wrap:
  - Stimulus: assert `reset` while in MEMREAD.
  - Required: next state is 0, all enables are 0 during reset, and `instret=0`.
  - Stimulus: with `W=4`, retire 16 instructions.
  - Required: `instret` reads 15 then wraps to 0.

Source files
------------

// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// funct codes, aluop and datapath mux selects.
package mips_multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_REGB  = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States whose next edge always retires the instruction into FETCH.
  function automatic logic is_final(input state_t s);
    return (s == S_MEMWB) || (s == S_MEMWRITE) || (s == S_ALUWB) ||
           (s == S_BRANCH) || (s == S_ADDIWB) || (s == S_JUMP);
  endfunction

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// Combinational ALU decoder: (aluop, funct) -> ALU F encoding.
module alu_decoder
  import mips_multicycle_control_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the shared-memory multicycle MIPS datapath.
// state      | meaning
// FETCH(0)   | read instr into IR, PC += 4
// DECODE(1)  | read regs, precompute branch target
// MEMADR(2)  | base + signimm address for lw/sw
// MEMREAD(3) | read data memory
// MEMWB(4)   | write loaded word to rt
// MEMWRITE(5)| store regB to memory
// EXECUTE(6) | R-type ALU operation
// ALUWB(7)   | write ALU result to rd
// BRANCH(8)  | compare, take branch if zero
// ADDIEXEC(9)| regA + signimm
// ADDIWB(10) | write addi result to rt
// JUMP(11)   | load jump target into PC
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [5:0]   op,
  input  logic [5:0]   funct,
  input  logic         zero,
  output logic         pcen,
  output logic         pcwrite,
  output logic         branch,
  output logic         irwrite,
  output logic         regwrite,
  output logic         memwrite,
  output logic         iord,
  output logic         regdst,
  output logic         memtoreg,
  output logic         alusrca,
  output logic [1:0]   alusrcb,
  output logic [1:0]   pcsrc,
  output logic [2:0]   alucontrol,
  output logic [3:0]   state,
  output logic [W-1:0] instret
);

  state_t     state_q, state_d;
  logic [1:0] aluop;
  logic       pcwrite_s, branch_s, irwrite_s, regwrite_s, memwrite_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      instret <= '0;
    end else begin
      state_q <= state_d;
      if (is_final(state_q)) instret <= instret + W'(1);
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    irwrite_s  = 1'b0;
    regwrite_s = 1'b0;
    memwrite_s = 1'b0;
    iord       = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = SRCB_REGB;
    pcsrc      = PCSRC_ALU;
    aluop      = ALUOP_ADD;
    case (state_q)
      S_FETCH: begin
        irwrite_s = 1'b1;
        pcwrite_s = 1'b1;
        alusrcb   = SRCB_FOUR;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        alusrcb = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDIEXEC;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWRITE: begin
        iord       = 1'b1;
        memwrite_s = 1'b1;
      end
      S_EXECUTE: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite_s = 1'b1;
      end
      S_BRANCH: begin
        alusrca  = 1'b1;
        aluop    = ALUOP_SUB;
        pcsrc    = PCSRC_ALUOUT;
        branch_s = 1'b1;
      end
      S_ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        state_d = S_ADDIWB;
      end
      S_ADDIWB: regwrite_s = 1'b1;
      S_JUMP: begin
        pcsrc     = PCSRC_JUMP;
        pcwrite_s = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  // Write enables are suppressed while reset is held so nothing is corrupted.
  assign pcwrite  = pcwrite_s  & ~reset;
  assign branch   = branch_s   & ~reset;
  assign irwrite  = irwrite_s  & ~reset;
  assign regwrite = regwrite_s & ~reset;
  assign memwrite = memwrite_s & ~reset;
  assign pcen     = pcwrite | (branch & zero);
  assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: per-cycle expected state, controls
// and instret are queued from a reference model and popped against the DUT.
module tb_mips_multicycle_control;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [5:0]   op, funct;
  logic         zero;
  logic         pcen, pcwrite, branch, irwrite, regwrite, memwrite;
  logic         iord, regdst, memtoreg, alusrca;
  logic [1:0]   alusrcb, pcsrc;
  logic [2:0]   alucontrol;
  logic [3:0]   state;
  logic [W-1:0] instret;

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] ctrl;
    logic [3:0]  ir;
  } exp_t;

  exp_t       sb[$];
  logic [3:0] instret_m;
  int         checks = 0;
  int         passed = 0;

  always #5 clk = ~clk;

  mips_multicycle_control #(.W(W)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcen(pcen), .pcwrite(pcwrite), .branch(branch), .irwrite(irwrite),
    .regwrite(regwrite), .memwrite(memwrite), .iord(iord), .regdst(regdst),
    .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
    .alucontrol(alucontrol), .state(state), .instret(instret)
  );

  // Reference model of the control word for one state.
  function automatic logic [16:0] model_ctrl(input logic [3:0] s, input logic [5:0] fn,
                                             input logic z, input logic rst);
    logic pw, br, irw, rw, mw, iod, rd, m2r, asa, pe;
    logic [1:0] asb, psrc, aop;
    logic [2:0] ac;
    {pw, br, irw, rw, mw, iod, rd, m2r, asa} = '0;
    asb = 2'b00; psrc = 2'b00; aop = 2'b00;
    case (s)
      4'd0:  begin irw = 1; pw = 1; asb = 2'b01; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  iod = 1;
      4'd4:  begin m2r = 1; rw = 1; end
      4'd5:  begin iod = 1; mw = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rd = 1; rw = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; psrc = 2'b01; br = 1; end
      4'd9:  begin asa = 1; asb = 2'b10; end
      4'd10: rw = 1;
      4'd11: begin psrc = 2'b10; pw = 1; end
      default: ;
    endcase
    case (aop)
      2'b01: ac = 3'b110;
      2'b10: case (fn)
               6'b100010: ac = 3'b110;
               6'b100100: ac = 3'b000;
               6'b100101: ac = 3'b001;
               6'b101010: ac = 3'b111;
               default:   ac = 3'b010;
             endcase
      default: ac = 3'b010;
    endcase
    pe = pw | (br & z);
    if (rst) {pw, br, irw, rw, mw, pe} = '0;
    return {pe, pw, br, irw, rw, mw, iod, rd, m2r, asa, asb, psrc, ac};
  endfunction

  task automatic push(input logic [3:0] s);
    exp_t e;
    e.st   = s;
    e.ctrl = model_ctrl(s, funct, zero, reset);
    e.ir   = instret_m;
    sb.push_back(e);
    if (s inside {4'd4, 4'd5, 4'd7, 4'd8, 4'd10, 4'd11}) instret_m = instret_m + 4'd1;
  endtask

  task automatic check(input string tag, input logic [16:0] obs, input logic [16:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h (state=%0d)", tag, obs, exp, state);
  endtask

  // Pop one expected cycle, compare it, then advance one clock.
  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      #1;
      check("state", {13'd0, state}, {13'd0, e.st});
      check("ctrl", {pcen, pcwrite, branch, irwrite, regwrite, memwrite, iord, regdst,
                     memtoreg, alusrca, alusrcb, pcsrc, alucontrol}, e.ctrl);
      check("instret", {13'd0, instret}, {13'd0, e.ir});
      @(negedge clk);
    end
  endtask

  task automatic do_instr(input logic [5:0] o, input logic [5:0] fn, input logic z);
    op = o; funct = fn; zero = z;
    push(4'd0);
    push(4'd1);
    case (o)
      6'b100011: begin push(4'd2); push(4'd3); push(4'd4); end
      6'b101011: begin push(4'd2); push(4'd5); end
      6'b000000: begin push(4'd6); push(4'd7); end
      6'b000100: push(4'd8);
      6'b001000: begin push(4'd9); push(4'd10); end
      6'b000010: push(4'd11);
      default: ;
    endcase
    drain();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] fns [6];
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
    reset = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b0;
    instret_m = 4'd0;
    @(negedge clk);
    push(4'd0); push(4'd0);
    drain();
    reset = 1'b0;

    do_instr(6'b100011, 6'd0, 1'b0);
    do_instr(6'b101011, 6'd0, 1'b0);
    foreach (fns[i]) do_instr(6'b000000, fns[i], 1'b0);
    do_instr(6'b000100, 6'd0, 1'b1);
    do_instr(6'b000100, 6'd0, 1'b0);
    do_instr(6'b000010, 6'd0, 1'b1);
    do_instr(6'b001000, 6'd0, 1'b0);
    do_instr(6'b111111, 6'd0, 1'b0);

    // lw interrupted by reset while in MEMREAD.
    op = 6'b100011; funct = 6'd0; zero = 1'b1;
    push(4'd0); push(4'd1); push(4'd2);
    drain();
    reset = 1'b1;
    push(4'd3);
    drain();
    instret_m = 4'd0;
    push(4'd0);
    drain();
    reset = 1'b0;

    for (int k = 0; k < 16; k++) do_instr(6'b000100, 6'd0, k[0]);
    push(4'd0);
    drain();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
